fu_sequencer: RTL and testbench

Multi-cycle controller that sequences the 8-bit function unit (arithmetic, logic and shift datapath selected by a 4-bit function select). It owns a small operand register file, accepts operation commands over a valid/ready handshake, and presents operands and the function select to the function unit. It writes the result back and latches the V/C/N/Z status, with an optional repeat count for iterated operations such as multi-bit shifts.

---
 rtl/fu_seq_pkg.sv | 32 +++
 rtl/fu_sequencer_if.sv | 59 +++++
 rtl/fu_seq_regfile.sv | 45 ++++
 rtl/fu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_seq_pkg.sv
// ============================================================================
//  Module   : fu_seq_pkg
//  Purpose  : Shared types and constants for the function-unit sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fu_seq_pkg;

   localparam int FSEL_W = 4;
   localparam int RPT_W  = 3;

   // Function-select groups, taken from the two most significant select bits
   localparam logic [1:0] AU0   = 2'b00;
   localparam logic [1:0] AU1   = 2'b01;
   localparam logic [1:0] LOGIC = 2'b10;
   localparam logic [1:0] SHIFT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   function automatic logic [1:0] fsel_group(input logic [FSEL_W-1:0] fsel);
      return fsel[FSEL_W-1 -: 2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/fu_sequencer_if.sv
// ============================================================================
//  Module   : fu_seq_if
//  Purpose  : Command, load, debug-read and function-unit signals of the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fu_seq_if #(
   parameter int WIDTH  = 8,
   parameter int REG_AW = 2
);
   import fu_seq_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [FSEL_W-1:0]    cmd_fsel;
   logic [REG_AW-1:0]    cmd_dst;
   logic [REG_AW-1:0]    cmd_srca;
   logic [REG_AW-1:0]    cmd_srcb;
   logic [RPT_W-1:0]     cmd_rpt;

   logic                 load_en;
   logic [REG_AW-1:0]    load_addr;
   logic [WIDTH-1:0]     load_data;

   logic [REG_AW-1:0]    rd_addr;
   logic [WIDTH-1:0]     rd_data;

   logic [FSEL_W-1:0]    fu_sel;
   logic [WIDTH-1:0]     fu_a;
   logic [WIDTH-1:0]     fu_b;
   logic [WIDTH-1:0]     fu_out;
   logic                 fu_v;
   logic                 fu_c;
   logic                 fu_n;
   logic                 fu_z;

   logic                 done;
   logic [WIDTH-1:0]     result;
   logic [3:0]           status;

   // Master issues commands and implements the function unit
   modport master (
      output cmd_valid, cmd_fsel, cmd_dst, cmd_srca, cmd_srcb, cmd_rpt,
      output load_en, load_addr, load_data, rd_addr,
      output fu_out, fu_v, fu_c, fu_n, fu_z,
      input  cmd_ready, rd_data, fu_sel, fu_a, fu_b, done, result, status
   );

   modport slave (
      input  cmd_valid, cmd_fsel, cmd_dst, cmd_srca, cmd_srcb, cmd_rpt,
      input  load_en, load_addr, load_data, rd_addr,
      input  fu_out, fu_v, fu_c, fu_n, fu_z,
      output cmd_ready, rd_data, fu_sel, fu_a, fu_b, done, result, status
   );

endinterface

`default_nettype wire

// File: rtl/fu_seq_regfile.sv
// ============================================================================
//  Module   : fu_seq_regfile
//  Purpose  : Operand register file, one write port and three async read ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_seq_regfile #(
   parameter int WIDTH  = 8,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [WIDTH-1:0]  ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [WIDTH-1:0]  rb_data,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam int DEPTH = 2 ** REG_AW;

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign ra_data = r_mem[ra_addr];
   assign rb_data = r_mem[rb_addr];
   assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fu_sequencer.sv
// ============================================================================
//  Module   : fu_sequencer
//  Purpose  : Multi-cycle READ/EXEC/WB controller for the 8-bit function unit.
//             Optional feature macro: FU_SEQ_STATUS_EN (V/C/N/Z status latch).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_sequencer
   import fu_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int REG_AW = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   fu_seq_if.slave  bus
);

   state_t             r_state;
   state_t             w_next;

   logic [FSEL_W-1:0]  r_fsel;
   logic [REG_AW-1:0]  r_dst;
   logic [REG_AW-1:0]  r_srca;
   logic [REG_AW-1:0]  r_srcb;
   logic [RPT_W-1:0]   r_cnt;

   logic [FSEL_W-1:0]  r_fu_sel;
   logic [WIDTH-1:0]   r_fu_a;
   logic [WIDTH-1:0]   r_fu_b;
   logic [WIDTH-1:0]   r_result;

   logic               w_ready;
   logic               w_done;
   logic               w_accept;
   logic               w_we;
   logic [REG_AW-1:0]  w_waddr;
   logic [WIDTH-1:0]   w_wdata;
   logic [WIDTH-1:0]   w_ra_data;
   logic [WIDTH-1:0]   w_rb_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Write port: direct loads only while idle, writeback owns it in WB
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_done  = 1'b0;
      w_we    = 1'b0;
      w_waddr = bus.load_addr;
      w_wdata = bus.load_data;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            w_we    = bus.load_en;
            if (bus.cmd_valid) begin
               w_next = READ;
            end
         end
         READ: w_next = EXEC;
         EXEC: w_next = WB;
         WB: begin
            w_we    = 1'b1;
            w_waddr = r_dst;
            w_wdata = r_result;
            if (r_cnt == '0) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else begin
               w_next = READ;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept = w_ready & bus.cmd_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsel   <= '0;
         r_dst    <= '0;
         r_srca   <= '0;
         r_srcb   <= '0;
         r_cnt    <= '0;
         r_fu_sel <= '0;
         r_fu_a   <= '0;
         r_fu_b   <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_fsel <= bus.cmd_fsel;
            r_dst  <= bus.cmd_dst;
            r_srca <= bus.cmd_srca;
            r_srcb <= bus.cmd_srcb;
            r_cnt  <= bus.cmd_rpt;
         end
         if (r_state == READ) begin
            r_fu_sel <= r_fsel;
            r_fu_a   <= w_ra_data;
            r_fu_b   <= w_rb_data;
         end
         if (r_state == EXEC) begin
            r_result <= bus.fu_out;
         end
         if (r_state == WB && r_cnt != '0) begin
            r_cnt <= r_cnt - RPT_W'(1);
         end
      end
   end

`ifdef FU_SEQ_STATUS_EN
   logic [3:0] r_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= '0;
      end else if (r_state == EXEC) begin
         r_flags <= {bus.fu_v, bus.fu_c, bus.fu_n, bus.fu_z};
      end
   end

   assign bus.status = r_flags;
`else
   logic w_unused_flags;
   assign w_unused_flags = ^{bus.fu_v, bus.fu_c, bus.fu_n, bus.fu_z};
   assign bus.status     = 4'b0000;
`endif

   fu_seq_regfile #(
      .WIDTH  (WIDTH),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (w_we),
      .waddr   (w_waddr),
      .wdata   (w_wdata),
      .ra_addr (r_srca),
      .ra_data (w_ra_data),
      .rb_addr (r_srcb),
      .rb_data (w_rb_data),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );

   assign bus.cmd_ready = w_ready;
   assign bus.done      = w_done;
   assign bus.fu_sel    = r_fu_sel;
   assign bus.fu_a      = r_fu_a;
   assign bus.fu_b      = r_fu_b;
   assign bus.result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_fu_sequencer.sv
// ============================================================================
//  Module   : tb_fu_sequencer
//  Purpose  : Scoreboard bench for fu_sequencer with a behavioural function unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fu_sequencer;
   import fu_seq_pkg::*;

   localparam int WIDTH  = 8;
   localparam int REG_AW = 2;

   typedef struct {
      logic [7:0] res;
      logic [3:0] st;
      int         acc;
      int         rpt;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   exp_t       q[$];
   exp_t       mon_e;
   logic [7:0] m [4];

   fu_seq_if #(.WIDTH(WIDTH), .REG_AW(REG_AW)) bus ();

   fu_sequencer #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   // Function unit: returns {V,C,N,Z,out}
   function automatic logic [11:0] fu_model(input logic [3:0] fs, input logic [7:0] a,
                                            input logic [7:0] b);
      int u;
      int s;
      logic [7:0] o;
      logic v;
      logic c;
      u = 0; s = 0; o = 8'h00; v = 1'b0; c = 1'b0;
      case (fsel_group(fs))
         AU0, AU1: begin
            if (fs[0]) begin
               u = int'(a) - int'(b);
               s = int'($signed(a)) - int'($signed(b));
               c = (u < 0);
            end else begin
               u = int'(a) + int'(b);
               s = int'($signed(a)) + int'($signed(b));
               c = (u > 255);
            end
            o = u[7:0];
            v = (s > 127) || (s < -128);
         end
         LOGIC: begin
            case (fs[1:0])
               2'd0:    o = a & b;
               2'd1:    o = a | b;
               2'd2:    o = a ^ b;
               default: o = ~a;
            endcase
         end
         default: begin
            case (fs[1:0])
               2'd0:    begin o = b >> 1;          c = b[0]; end
               2'd1:    begin o = b << 1;          c = b[7]; end
               2'd2:    begin o = {b[0], b[7:1]};  c = b[0]; end
               default: begin o = {b[6:0], b[7]};  c = b[7]; end
            endcase
         end
      endcase
      return {v, c, o[7], (o == 8'h00), o};
   endfunction

   always_comb begin
      {bus.fu_v, bus.fu_c, bus.fu_n, bus.fu_z, bus.fu_out} = fu_model(bus.fu_sel, bus.fu_a, bus.fu_b);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("result", 32'(bus.result), 32'(mon_e.res));
            chk("status", 32'(bus.status), 32'(mon_e.st));
            chk("latency", 32'(cyc - mon_e.acc), 32'(3 * (mon_e.rpt + 1)));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_load(input logic [1:0] a, input logic [7:0] d);
      wait_ready();
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      m[a] = d;
      @(negedge clk);
      bus.load_en = 1'b0;
   endtask

   // Returns at the falling edge inside READ (cycle 1 after accept)
   task automatic issue(input logic [3:0] fs, input logic [1:0] d, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [2:0] rpt,
                        input logic le = 1'b0, input logic [1:0] la = 2'd0,
                        input logic [7:0] ld = 8'h00);
      exp_t       e;
      logic [11:0] r;
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_fsel  = fs;
      bus.cmd_dst   = d;
      bus.cmd_srca  = sa;
      bus.cmd_srcb  = sb;
      bus.cmd_rpt   = rpt;
      bus.load_en   = le;
      bus.load_addr = la;
      bus.load_data = ld;
      if (le) m[la] = ld;
      r = 12'h000;
      for (int k = 0; k <= int'(rpt); k++) begin
         r = fu_model(fs, m[sa], m[sb]);
         m[d] = r[7:0];
      end
      e.res = r[7:0];
`ifdef FU_SEQ_STATUS_EN
      e.st = r[11:8];
`else
      e.st = 4'b0000;
`endif
      e.acc = cyc;
      e.rpt = int'(rpt);
      q.push_back(e);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.load_en   = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || !bus.cmd_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("done_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic check_regs();
      for (int i = 0; i < 4; i++) begin
         bus.rd_addr = 2'(i);
         #1;
         chk($sformatf("rd_data[%0d]", i), 32'(bus.rd_data), 32'(m[i]));
      end
   endtask

   initial begin
      logic [7:0] shift_exp [3];
      checks = 0;
      errors = 0;
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      bus.cmd_valid = 1'b0; bus.cmd_fsel = 4'h0; bus.cmd_dst = 2'd0;
      bus.cmd_srca  = 2'd0; bus.cmd_srcb = 2'd0; bus.cmd_rpt = 3'd0;
      bus.load_en   = 1'b0; bus.load_addr = 2'd0; bus.load_data = 8'h00;
      bus.rd_addr   = 2'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_result", 32'(bus.result), 32'd0);
      chk("reset_status", 32'(bus.status), 32'd0);
      chk("reset_fu_sel", 32'(bus.fu_sel), 32'd0);
      check_regs();

      // Basic add: r3 = r1 + r2
      do_load(2'd1, 8'h12);
      do_load(2'd2, 8'h34);
      issue(4'b0000, 2'd3, 2'd1, 2'd2, 3'd0);
      chk("ready_busy", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      chk("exec_fu_a", 32'(bus.fu_a), 32'h12);
      chk("exec_fu_b", 32'(bus.fu_b), 32'h34);
      chk("exec_fu_sel", 32'(bus.fu_sel), 32'h0);
      wait_idle();
      check_regs();

      // Iterated shift-left on one register
      shift_exp[0] = 8'h81; shift_exp[1] = 8'h02; shift_exp[2] = 8'h04;
      do_load(2'd0, 8'h81);
      issue(4'b1101, 2'd0, 2'd0, 2'd0, 3'd2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("shift_fu_b[%0d]", k), 32'(bus.fu_b), 32'(shift_exp[k]));
         if (k < 2) repeat (2) @(negedge clk);
      end
      wait_idle();
      chk("shift_r0", 32'(m[0]), 32'h08);
      check_regs();

      // Flags: 0xFF + 0x01 = 0x00 with carry and zero
      do_load(2'd1, 8'hFF);
      do_load(2'd2, 8'h01);
      issue(4'b0000, 2'd3, 2'd1, 2'd2, 3'd0);
      wait_idle();
`ifdef FU_SEQ_STATUS_EN
      chk("flag_status", 32'(bus.status), 32'b0101);
`else
      chk("flag_status", 32'(bus.status), 32'b0000);
`endif

      // Load while busy is ignored
      issue(4'b0001, 2'd3, 2'd1, 2'd2, 3'd1);
      bus.load_en = 1'b1; bus.load_addr = 2'd2; bus.load_data = 8'hFF;
      repeat (3) @(negedge clk);
      bus.load_en = 1'b0;
      wait_idle();
      check_regs();

      // Load and accept in the same cycle: READ sees the new value
      issue(4'b0000, 2'd0, 2'd2, 2'd1, 3'd0, 1'b1, 2'd2, 8'h55);
      wait_idle();
      check_regs();

      // Reset during EXEC
      issue(4'b1000, 2'd1, 2'd0, 2'd3, 3'd0);
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      #1;
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_fu_b", 32'(bus.fu_b), 32'd0);
      check_regs();
      @(negedge clk);
      rst_n = 1'b1;
      do_load(2'd1, 8'h03);
      do_load(2'd2, 8'h04);
      issue(4'b0001, 2'd3, 2'd1, 2'd2, 3'd0);
      wait_idle();
      check_regs();

      // Randomised commands against the reference model
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0) do_load(2'($urandom_range(0, 3)), 8'($urandom));
         issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 8'($urandom));
         if ($urandom_range(0, 1) == 0) begin
            wait_idle();
            check_regs();
         end
      end
      wait_idle();
      check_regs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
